// File: rtl/register_file.sv
// 32-entry MIPS general-purpose register file: two combinational read ports,
// one synchronous write port driven through a one-hot write-enable decoder.
module register_file #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ADDR_WIDTH   = 5,
    parameter int unsigned WRITE_BYPASS = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] read_reg1,
    input  logic [ADDR_WIDTH-1:0] read_reg2,
    input  logic [ADDR_WIDTH-1:0] write_reg,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  reg_write,
    output logic [DATA_WIDTH-1:0] read_data1,
    output logic [DATA_WIDTH-1:0] read_data2,
    input  logic [ADDR_WIDTH-1:0] dbg_reg,
    output logic [DATA_WIDTH-1:0] dbg_data
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [DEPTH-1:0]      w_we_onehot;
    logic [DATA_WIDTH-1:0] w_stored [DEPTH];
    logic                  w_byp_en;
    logic                  w_byp1;
    logic                  w_byp2;

    // 5-to-32 write decoder; index 0 never enabled
    always_comb begin
        w_we_onehot = '0;
        if (reg_write && (write_reg != '0)) begin
            w_we_onehot[write_reg] = 1'b1;
        end
    end

    // $zero is hardwired, not stored
    assign w_stored[0] = '0;

    for (genvar gi = 1; gi < DEPTH; gi++) begin : g_reg
        logic [DATA_WIDTH-1:0] r_q;

        always_ff @(posedge clk) begin
            if (reset) begin
                r_q <= '0;
            end else if (w_we_onehot[gi]) begin
                r_q <= write_data;
            end
        end

        assign w_stored[gi] = r_q;
    end

    // Forwarding of in-flight write data; suppressed under reset and for $zero
    assign w_byp_en = (WRITE_BYPASS != 0) && !reset && reg_write && (write_reg != '0);
    assign w_byp1   = w_byp_en && (read_reg1 == write_reg);
    assign w_byp2   = w_byp_en && (read_reg2 == write_reg);

    assign read_data1 = w_byp1 ? write_data : w_stored[read_reg1];
    assign read_data2 = w_byp2 ? write_data : w_stored[read_reg2];
    assign dbg_data   = w_stored[dbg_reg];

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: both bypass builds share one stimulus
// stream; expected reads come from an array model of the architectural state.
module tb_register_file;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  read_reg1, read_reg2, write_reg, dbg_reg;
    logic [31:0] write_data;
    logic        reg_write;
    logic [31:0] rd1_nb, rd2_nb, dbg_nb;
    logic [31:0] rd1_b, rd2_b, dbg_b;

    always #5 clk = ~clk;

    register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .WRITE_BYPASS(0)) u_dut_nb (
        .clk(clk), .reset(reset),
        .read_reg1(read_reg1), .read_reg2(read_reg2),
        .write_reg(write_reg), .write_data(write_data), .reg_write(reg_write),
        .read_data1(rd1_nb), .read_data2(rd2_nb),
        .dbg_reg(dbg_reg), .dbg_data(dbg_nb)
    );

    register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .WRITE_BYPASS(1)) u_dut_b (
        .clk(clk), .reset(reset),
        .read_reg1(read_reg1), .read_reg2(read_reg2),
        .write_reg(write_reg), .write_data(write_data), .reg_write(reg_write),
        .read_data1(rd1_b), .read_data2(rd2_b),
        .dbg_reg(dbg_reg), .dbg_data(dbg_b)
    );

    typedef struct {
        logic [31:0] rd1_nb;
        logic [31:0] rd2_nb;
        logic [31:0] dbg;
        logic [31:0] rd1_b;
        logic [31:0] rd2_b;
        int          id;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] model [32];
    int          total = 0;
    int          bad   = 0;
    int          n_issued = 0;
    bit          stim_done = 1'b0;

    task automatic check(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s id=%0d got=%08h want=%08h", name, id, act, exp);
        end
    endtask

    // Architectural read value of one port in the current cycle
    function automatic logic [31:0] ref_read(input logic [4:0] idx, input bit bypass,
                                             input logic rst, input logic we,
                                             input logic [4:0] wr, input logic [31:0] wd);
        if (idx == 5'd0) return 32'h0;
        if (bypass && !rst && we && (idx == wr)) return wd;
        return model[idx];
    endfunction

    // Apply one cycle of inputs; push expected reads, then advance the model past the edge
    task automatic drive(input logic rst, input logic we, input logic [4:0] r1, input logic [4:0] r2,
                         input logic [4:0] wr, input logic [31:0] wd, input logic [4:0] dbg, input bit chk);
        exp_t e;
        @(negedge clk);
        reset = rst; reg_write = we; read_reg1 = r1; read_reg2 = r2;
        write_reg = wr; write_data = wd; dbg_reg = dbg;
        if (chk) begin
            e.rd1_nb = ref_read(r1, 1'b0, rst, we, wr, wd);
            e.rd2_nb = ref_read(r2, 1'b0, rst, we, wr, wd);
            e.rd1_b  = ref_read(r1, 1'b1, rst, we, wr, wd);
            e.rd2_b  = ref_read(r2, 1'b1, rst, we, wr, wd);
            e.dbg    = (dbg == 5'd0) ? 32'h0 : model[dbg];
            e.id     = n_issued;
            n_issued++;
            exp_q.push_back(e);
        end
        if (rst) begin
            for (int k = 0; k < 32; k++) model[k] = 32'h0;
        end else if (we && wr != 5'd0) begin
            model[wr] = wd;
        end
    endtask

    task automatic rd(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] dbg);
        drive(1'b0, 1'b0, r1, r2, 5'($urandom), $urandom, dbg, 1'b1);
    endtask

    task automatic wr(input logic [4:0] idx, input logic [31:0] wd, input logic [4:0] r1, input logic [4:0] r2);
        drive(1'b0, 1'b1, r1, r2, idx, wd, idx, 1'b1);
    endtask

    // Monitor: compare every queued expectation against the settled outputs just before the edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("rd1_nobyp", e.id, rd1_nb, e.rd1_nb);
                check("rd2_nobyp", e.id, rd2_nb, e.rd2_nb);
                check("dbg_nobyp", e.id, dbg_nb, e.dbg);
                check("rd1_byp",   e.id, rd1_b,  e.rd1_b);
                check("rd2_byp",   e.id, rd2_b,  e.rd2_b);
                check("dbg_byp",   e.id, dbg_b,  e.dbg);
            end
        end
    end

    initial begin
        logic [4:0]  ri, rj, rw;
        logic [31:0] rdat;
        reset = 1'b0; reg_write = 1'b0; read_reg1 = '0; read_reg2 = '0;
        write_reg = '0; write_data = '0; dbg_reg = '0;
        for (int k = 0; k < 32; k++) model[k] = 32'h0;

        // Single reset cycle (pre-reset contents are unknown), then sweep all indices
        drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 5'd0, 1'b0);
        for (int i = 0; i < 32; i++) rd(5'(i), 5'(31 - i), 5'(i));

        // Write every register while reading it back in the same cycle, then sweep
        for (int i = 1; i < 32; i++) wr(5'(i), 32'hA5A5_0000 | 32'(i), 5'(i), 5'(i));
        for (int i = 0; i < 32; i++) rd(5'(i), 5'(i), 5'(i));

        // $zero protection, same cycle and after the edge
        wr(5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
        rd(5'd0, 5'd0, 5'd0);

        // Collision on register 8
        wr(5'd8, 32'h1111_1111, 5'd1, 5'd2);
        wr(5'd8, 32'h2222_2222, 5'd8, 5'd8);
        rd(5'd8, 5'd8, 5'd8);

        // Write disabled leaves register 9 alone
        drive(1'b0, 1'b0, 5'd9, 5'd9, 5'd9, 32'hDEAD_BEEF, 5'd9, 1'b1);
        rd(5'd9, 5'd9, 5'd9);

        // Reset dominates a concurrent write; following write succeeds
        wr(5'd31, 32'h1234_5678, 5'd3, 5'd4);
        drive(1'b1, 1'b1, 5'd31, 5'd31, 5'd31, 32'hCAFE_F00D, 5'd31, 1'b1);
        rd(5'd31, 5'd8, 5'd31);
        wr(5'd31, 32'hCAFE_F00D, 5'd31, 5'd0);
        rd(5'd31, 5'd31, 5'd31);

        // Random traffic with biased collisions and occasional reset
        for (int n = 0; n < 600; n++) begin
            rw   = 5'($urandom);
            rdat = $urandom;
            ri   = ($urandom_range(0, 3) == 0) ? rw : 5'($urandom);
            rj   = ($urandom_range(0, 3) == 0) ? rw : 5'($urandom);
            drive(($urandom_range(0, 63) == 0), ($urandom_range(0, 2) != 0),
                  ri, rj, rw, rdat, 5'($urandom), 1'b1);
        end
        for (int i = 0; i < 32; i++) rd(5'(i), 5'(i), 5'(i));

        @(negedge clk);
        @(negedge clk);
        #5;
        stim_done = 1'b1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain got=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        if (!stim_done) begin
            $display("FAIL timeout got=running want=finished");
            $fatal(1, "timeout");
        end
    end

endmodule
